// File: rtl/rs_cw_err_apply.sv
// Codeword buffer and error applicator placed after the Chien/Forney stage. It loads one
// RS(544,514) codeword, applies the Forney XOR corrections, then streams the corrected word out.
// Optional build macro RS_CORR_STATS_EN enables the per-frame correction counter.
module rs_cw_err_apply #(
    parameter int W     = 10,
    parameter int N_SYM = 544,
    parameter int N     = 1023,
    parameter int POS_W = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    input  logic [W-1:0]     in_data_i,
    input  logic             forney_vld_i,
    output logic             forney_rdy_o,
    input  logic [POS_W-1:0] forney_pos_i,
    input  logic [W-1:0]     forney_y_i,
    input  logic             forney_den_zero_i,
    input  logic             corr_done_i,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic [W-1:0]     out_data_o,
    output logic             out_last_o,
    output logic             frame_err_o,
    output logic [POS_W-1:0] corr_cnt_o
);

    localparam int PTR_W = $clog2(N_SYM);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_SYM - 1);
    localparam logic [PTR_W-1:0] PRE_LAST = PTR_W'(N_SYM - 2);

    typedef enum logic [1:0] {IDLE, LOAD, CORR, DRAIN} state_t;

    state_t           state;
    logic [W-1:0]     mem [N_SYM];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;

    logic             in_fire;
    logic             corr_fire;
    logic             pos_ok;
    logic             out_fire;
    logic [PTR_W-1:0] corr_idx;

    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [W-1:0]     wr_data;

    // The ready flags are registered and only high in their own state, so every
    // handshake is already qualified by the state.
    assign in_fire   = in_vld_i & in_rdy_o;
    assign corr_fire = forney_vld_i & forney_rdy_o;
    assign out_fire  = out_vld_o & out_rdy_i;
    assign pos_ok    = {{(32-POS_W){1'b0}}, forney_pos_i} < 32'(N_SYM);
    assign corr_idx  = forney_pos_i[PTR_W-1:0];

    // Single write port shared by the load and the read-modify-write correction.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = wp;
        wr_data = in_data_i;
        if (in_fire) begin
            wr_en = 1'b1;
        end else if (corr_fire && pos_ok) begin
            wr_en   = 1'b1;
            wr_idx  = corr_idx;
            wr_data = mem[corr_idx] ^ forney_y_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read is combinational so a correction applied in the corr_done cycle is
    // already visible on the first drained symbol.
    assign out_data_o = out_vld_o ? mem[rp] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            wp           <= '0;
            rp           <= '0;
            in_rdy_o     <= 1'b0;
            forney_rdy_o <= 1'b0;
            out_vld_o    <= 1'b0;
            out_last_o   <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= LOAD;
                    in_rdy_o    <= 1'b1;
                    frame_err_o <= 1'b0;
                end
                LOAD: begin
                    if (in_fire) begin
                        if (wp == LAST_IDX) begin
                            wp           <= '0;
                            state        <= CORR;
                            in_rdy_o     <= 1'b0;
                            forney_rdy_o <= 1'b1;
                        end else begin
                            wp <= wp + 1'b1;
                        end
                    end
                end
                CORR: begin
                    if (corr_fire && (!pos_ok || forney_den_zero_i)) begin
                        frame_err_o <= 1'b1;
                    end
                    if (corr_done_i) begin
                        state        <= DRAIN;
                        forney_rdy_o <= 1'b0;
                        out_vld_o    <= 1'b1;
                        out_last_o   <= (N_SYM == 1);
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (out_last_o) begin
                            state      <= IDLE;
                            rp         <= '0;
                            out_vld_o  <= 1'b0;
                            out_last_o <= 1'b0;
                        end else begin
                            rp         <= rp + 1'b1;
                            out_last_o <= (rp == PRE_LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RS_CORR_STATS_EN
    logic [POS_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state == IDLE) begin
            cnt_q <= '0;
        end else if (corr_fire && pos_ok && (cnt_q != {POS_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign corr_cnt_o = cnt_q;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i && corr_fire && pos_ok)
            $display("rs_cw_err_apply: correction pos=%0d y=0x%0h den_zero=%0b",
                     forney_pos_i, forney_y_i, forney_den_zero_i);
    end
`endif
`else
    assign corr_cnt_o = '0;
`endif

endmodule
